// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter in front of
// the async FIFO write port, one grant of up to BURST_LEN beats.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATASIZE  = 8,
  parameter  int BURST_LEN = 4,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                        wr_clk,
  input  logic                        wr_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATASIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [DATASIZE-1:0]         fifo_wr_data,
  output logic [IDW-1:0]              grant_id,
  output logic                        busy
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0]  LAST   = CW'(BURST_LEN - 1);
  localparam logic [IDW-1:0] RST_ID = IDW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [IDW-1:0]      pick;
  logic [IDW-1:0]      cand;
  logic                any;
  logic                cur_valid;
  logic [DATASIZE-1:0] cur_data;

  // Rotating search starting just above the last grantee.
  always_comb begin
    pick = grant_q;
    cand = '0;
    any  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(grant_q) + k) % NUM_REQ);
      if (!any && req_valid[cand]) begin
        any  = 1'b1;
        pick = cand;
      end
    end
  end

  // Next-state logic and the combinational write-port outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    busy         = 1'b0;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    cur_valid    = req_valid[grant_q];
    cur_data     = req_data[int'(grant_q)*DATASIZE +: DATASIZE];
    unique case (state_q)
      IDLE: begin
        if (any) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        busy               = 1'b1;
        req_ready[grant_q] = !fifo_full;
        fifo_wr_data       = cur_data;
        fifo_wr_en         = cur_valid && !fifo_full;
        if (!cur_valid) begin
          state_d = IDLE;
        end else if (!fifo_full) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // State, grant and beat counter registers.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q <= IDLE;
      grant_q <= RST_ID;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed stimulus with queued producers
// and a scoreboard of expected FIFO writes checked per cycle.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic           clk;
  logic           rst_n;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [DW-1:0]  fifo_wr_data;
  logic [1:0]     grant_id;
  logic           busy;

  fifo_wr_arbiter #(
    .NUM_REQ  (NR),
    .DATASIZE (DW),
    .BURST_LEN(4)
  ) dut (
    .wr_clk      (clk),
    .wr_rst_n    (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  typedef struct {
    int        cyc;
    int        id;
    logic [7:0] data;
  } exp_t;

  exp_t       exq[$];
  logic [7:0] mem[NR][32];
  int         head[NR];
  int         tail[NR];
  int         cyc;
  int         n_cmp;
  int         n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push_src(input int r, input logic [7:0] d);
    mem[r][tail[r]] = d;
    tail[r]++;
  endtask

  task automatic expect_wr(input int c, input int id,
                           input logic [7:0] d);
    exp_t e;
    e.cyc  = c;
    e.id   = id;
    e.data = d;
    exq.push_back(e);
  endtask

  task automatic wait_pos(input int c);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < c);
  endtask

  task automatic wait_neg(input int c);
    while (cyc < c || clk) @(negedge clk);
  endtask

  // Producers: present the head beat, advance on a handshake.
  initial begin
    logic [NR-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) head[i]++;
        req_valid[i] = head[i] < tail[i];
        req_data[i*DW +: DW] = req_valid[i] ? mem[i][head[i]] : '0;
      end
    end
  end

  // Monitor: invariants every cycle, writes against scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("inv_full", int'(fifo_wr_en && fifo_full), 0);
      chk("inv_onehot", int'($onehot0(req_ready)), 1);
      if (fifo_wr_en) begin
        if (exq.size() == 0) begin
          chk("wr_unexpected", int'(fifo_wr_en), 0);
        end else begin
          e = exq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_id", int'(grant_id), e.id);
          chk("wr_data", int'(fifo_wr_data), int'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_ready"}, int'(req_ready), 0);
    chk({nm, "_wr_en"}, int'(fifo_wr_en), 0);
    chk({nm, "_wr_data"}, int'(fifo_wr_data), 0);
    chk({nm, "_grant"}, int'(grant_id), 3);
  endtask

  initial begin
    int c0;
    cyc       = 0;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end

    wait_neg(1);
    chk_idle_outs("rst");
    wait_pos(3);
    rst_n = 1'b1;
    wait_neg(3);
    chk_idle_outs("post_rst");

    // 1: single requester, 6 beats, re-grant after one gap.
    wait_pos(4);
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      push_src(0, 8'(8'h10 + k));
      expect_wr(k < 4 ? c0 + 1 + k : c0 + 2 + k, 0, 8'(8'h10 + k));
    end
    wait_neg(c0);
    chk("t1_idle_busy", int'(busy), 0);
    wait_neg(c0 + 1);
    chk("t1_grant", int'(grant_id), 0);
    chk("t1_busy", int'(busy), 1);
    wait_neg(c0 + 5);
    chk("t1_gap_busy", int'(busy), 0);
    wait_neg(c0 + 6);
    chk("t1_regrant_busy", int'(busy), 1);
    chk("t1_regrant", int'(grant_id), 0);

    wait_pos(c0 + 10);
    rst_n = 1'b0;
    wait_pos(c0 + 11);
    rst_n = 1'b1;

    // 2: all requesters valid, order 0,1,2,3,0.
    wait_pos(c0 + 12);
    c0 = cyc;
    for (int k = 0; k < 8; k++) push_src(0, 8'h00);
    for (int r = 1; r < NR; r++)
      for (int k = 0; k < 4; k++) push_src(r, 8'(r));
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 4; k++)
        expect_wr(c0 + 1 + 5*b + k, b % 4, 8'(b % 4));
    for (int b = 0; b < 4; b++) begin
      wait_neg(c0 + 5 + 5*b);
      chk("t2_gap_busy", int'(busy), 0);
      wait_neg(c0 + 6 + 5*b);
      chk("t2_grant", int'(grant_id), (b + 1) % 4);
    end

    // 3: requester 2, FIFO full for 5 cycles after 2 beats.
    wait_pos(c0 + 27);
    c0 = cyc;
    for (int k = 0; k < 4; k++) push_src(2, 8'(8'h20 + k));
    expect_wr(c0 + 1, 2, 8'h20);
    expect_wr(c0 + 2, 2, 8'h21);
    expect_wr(c0 + 8, 2, 8'h22);
    expect_wr(c0 + 9, 2, 8'h23);
    wait_pos(c0 + 3);
    fifo_full = 1'b1;
    for (int c = 3; c < 8; c++) begin
      wait_neg(c0 + c);
      chk("t3_full_ready", int'(req_ready), 0);
      chk("t3_full_wr_en", int'(fifo_wr_en), 0);
      chk("t3_full_grant", int'(grant_id), 2);
      chk("t3_full_busy", int'(busy), 1);
    end
    wait_pos(c0 + 8);
    fifo_full = 1'b0;
    wait_neg(c0 + 8);
    chk("t3_resume_ready", int'(req_ready), 4);

    // 4: requester 1 drops early; 3 then 0 follow.
    wait_pos(c0 + 12);
    c0 = cyc;
    push_src(1, 8'hA1);
    expect_wr(c0 + 1, 1, 8'hA1);
    wait_pos(c0 + 1);
    push_src(3, 8'hB0);
    push_src(3, 8'hB1);
    push_src(0, 8'hC0);
    expect_wr(c0 + 4, 3, 8'hB0);
    expect_wr(c0 + 5, 3, 8'hB1);
    expect_wr(c0 + 8, 0, 8'hC0);
    wait_neg(c0 + 1);
    chk("t4_grant1", int'(grant_id), 1);
    wait_neg(c0 + 2);
    chk("t4_drop_busy", int'(busy), 1);
    chk("t4_drop_wr_en", int'(fifo_wr_en), 0);
    wait_neg(c0 + 3);
    chk("t4_release_busy", int'(busy), 0);
    wait_neg(c0 + 4);
    chk("t4_grant3", int'(grant_id), 3);
    wait_neg(c0 + 8);
    chk("t4_grant0", int'(grant_id), 0);

    // 5: asynchronous reset in the middle of a burst.
    wait_pos(c0 + 12);
    c0 = cyc;
    for (int k = 0; k < 4; k++) push_src(2, 8'(8'h50 + k));
    expect_wr(c0 + 1, 2, 8'h50);
    expect_wr(c0 + 2, 2, 8'h51);
    wait_pos(c0 + 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outs("t5_rst");
    wait_pos(c0 + 4);
    push_src(0, 8'h60);
    expect_wr(c0 + 5, 0, 8'h60);
    expect_wr(c0 + 8, 2, 8'h52);
    expect_wr(c0 + 9, 2, 8'h53);
    #2;
    rst_n = 1'b1;
    wait_neg(c0 + 5);
    chk("t5_first_grant", int'(grant_id), 0);
    wait_neg(c0 + 8);
    chk("t5_second_grant", int'(grant_id), 2);

    wait_pos(c0 + 13);
    chk("drain", exq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
